// File: rtl/f1_pkg.sv
// f1_pkg: loader state type, default frame size and lane helpers (F1_LOADER_BYTE_SWAP_EN selects big-endian lanes)
package f1_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} f1_state_e;
  localparam int F1_FRAME_BYTES = 1024;
  function automatic logic [1:0] byte_lane(input logic [1:0] k);
`ifdef F1_LOADER_BYTE_SWAP_EN
    return ~k;
`else
    return k;
`endif
  endfunction
  function automatic logic [3:0] lane_mask(input logic [1:0] n);
`ifdef F1_LOADER_BYTE_SWAP_EN
    return ~(4'hF >> n);
`else
    return ~(4'hF << n);
`endif
  endfunction
endpackage

// File: rtl/f1_byte_packer.sv
// f1_byte_packer: gathers accepted bytes into 32-bit words and produces write strobe, mask and data
module f1_byte_packer
  import f1_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        acc,
  input  logic        flush,
  input  logic [7:0]  data,
  output logic [1:0]  lanes,
  output logic        wr,
  output logic [3:0]  mask,
  output logic [31:0] wdata
);
  logic [31:0] word, word_in;
  logic full;
  always_comb begin
    word_in = word;
    word_in[8*byte_lane(lanes) +: 8] = data;
    full = acc && lanes == 2'd3;
    wr = full || (flush && lanes != 2'd0);
    mask = full ? 4'hF : lane_mask(lanes);
    wdata = full ? word_in : word;
  end
  always_ff @(posedge clk)
    if (rst || clr || flush) begin
      lanes <= 2'd0;
      word <= '0;
    end else if (acc) begin
      lanes <= lanes + 2'd1;
      word <= full ? '0 : word_in;
    end
endmodule

// File: rtl/f1_ram_loader.sv
// f1_ram_loader: streams feature bytes into the conv1 feature RAM as packed word writes (F1_LOADER_BYTE_SWAP_EN: big-endian packing)
module f1_ram_loader
  import f1_pkg::*;
#(
  parameter int          FRAME_BYTES = F1_FRAME_BYTES,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        wclk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic [3:0]  f1_wr_en,
  output logic [31:0] f1_waddr,
  output logic [31:0] f1_wdata,
  output logic        ena,
  output logic        busy,
  output logic        done
);
  localparam int CW = $clog2(FRAME_BYTES + 1);
  f1_state_e state, nxt;
  logic [CW-1:0] count, widx;
  logic [1:0] lanes;
  logic [3:0] mask;
  logic [31:0] pdata;
  logic acc, last, flush, wr;
  always_comb begin
    in_ready = state == LOAD;
    busy = state != IDLE;
    done = state == DONE;
    flush = state == FLUSH;
    acc = in_valid && in_ready;
    last = acc && (in_last || count == CW'(FRAME_BYTES - 1));
    nxt = state == IDLE ? (start ? LOAD : IDLE) :
          state == LOAD ? (last ? FLUSH : LOAD) :
          state == FLUSH ? (lanes == 2'd0 ? DONE : FLUSH) : IDLE;
  end
  f1_byte_packer u_packer (
    .clk(wclk), .rst(rst), .clr(done), .acc(acc), .flush(flush), .data(in_data),
    .lanes(lanes), .wr(wr), .mask(mask), .wdata(pdata)
  );
  always_ff @(posedge wclk) state <= rst ? IDLE : nxt;
  always_ff @(posedge wclk)
    if (rst) begin
      f1_wr_en <= 4'h0;
      f1_waddr <= '0;
      f1_wdata <= '0;
      ena <= 1'b0;
      count <= '0;
      widx <= '0;
    end else begin
      f1_wr_en <= wr ? mask : 4'h0;
      ena <= wr;
      if (wr) begin
        f1_waddr <= BASE_ADDR + 32'({widx, 2'b00});
        f1_wdata <= pdata;
      end
      count <= done ? '0 : count + CW'(acc);
      widx <= done ? '0 : widx + CW'(wr);
    end
endmodule

// File: tb/tb_f1_ram_loader.sv
// tb_f1_ram_loader: randomized scoreboard bench for f1_ram_loader against a byte-list reference model
module tb_f1_ram_loader;
  localparam int FB = 1024;
  localparam logic [31:0] BASE = 32'h0;
`ifdef F1_LOADER_BYTE_SWAP_EN
  localparam bit SWAP = 1'b1;
`else
  localparam bit SWAP = 1'b0;
`endif
  logic wclk = 1'b0, rst, start, in_valid, in_last, in_ready, ena, busy, done;
  logic [7:0] in_data;
  logic [3:0] f1_wr_en;
  logic [31:0] f1_waddr, f1_wdata;
  typedef struct packed {logic [31:0] a; logic [31:0] d; logic [3:0] m;} wr_t;
  wr_t expq[$];
  logic [7:0] fb[$];
  int vectors = 0, miscompares = 0, cyc = 0, last_wr = -10, dones = 0;
  bit expect_done = 1'b0;

  f1_ram_loader #(.FRAME_BYTES(FB), .BASE_ADDR(BASE)) dut (
    .wclk(wclk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .f1_wr_en(f1_wr_en), .f1_waddr(f1_waddr),
    .f1_wdata(f1_wdata), .ena(ena), .busy(busy), .done(done)
  );

  always #5 wclk = ~wclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: every group of four bytes is one word; the tail group is a masked partial word.
  task automatic push_model(input int n);
    for (int w = 0; w * 4 < n; w++) begin
      wr_t e;
      e.a = BASE + 32'(4 * w);
      e.d = '0;
      e.m = '0;
      for (int j = w * 4; j < n && j < w * 4 + 4; j++) begin
        int ln;
        ln = SWAP ? 3 - (j % 4) : j % 4;
        e.d = e.d | (32'(fb[j]) << (8 * ln));
        e.m[ln] = 1'b1;
      end
      expq.push_back(e);
    end
  endtask

  always @(negedge wclk) begin
    cyc++;
    if (!rst) begin
      if (ena || f1_wr_en != 4'h0) begin
        if (expq.size() == 0) check("unexpected_write", {28'h0, f1_wr_en}, 32'h0);
        else begin
          wr_t e;
          e = expq.pop_front();
          check("waddr", f1_waddr, e.a);
          check("wdata", f1_wdata, e.d);
          check("wr_en", {28'h0, f1_wr_en}, {28'h0, e.m});
          check("ena", 32'(ena), 32'd1);
        end
        last_wr = cyc;
      end
      if (done) begin
        check("done_expected", 32'(expect_done), 32'd1);
        check("done_queue_empty", 32'(expq.size()), 32'd0);
        check("done_latency", 32'(cyc - last_wr), 32'd1);
        expect_done = 1'b0;
        dones++;
      end
    end
  end

  task automatic run_frame(input bit use_last, input bit bp, input bit restart, input int rst_after);
    int n, i, t, d0, target;
    bit acc;
    n = fb.size() < FB ? fb.size() : FB;
    target = rst_after > 0 ? rst_after : n;
    push_model(rst_after > 0 ? rst_after / 4 * 4 : n);
    expect_done = rst_after == 0;
    d0 = dones;
    @(posedge wclk); #1 start = 1'b1;
    @(posedge wclk); #1 start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    i = 0;
    t = 0;
    while (i < target && t < 8000) begin
      in_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data = fb[i];
      in_last = use_last && i == fb.size() - 1;
      start = restart && i == n / 2;
      acc = in_valid && in_ready;
      @(posedge wclk); #1;
      if (acc) i++;
      t++;
    end
    start = 1'b0;
    in_last = 1'b0;
    check("bytes_accepted", 32'(i), 32'(target));
    if (rst_after > 0) begin
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge wclk); #1 rst = 1'b0;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_wr_en", {28'h0, f1_wr_en}, 32'd0);
      check("rst_waddr", f1_waddr, 32'd0);
      check("rst_wdata", f1_wdata, 32'd0);
      check("rst_ena_busy_done", {29'h0, ena, busy, done}, 32'd0);
      repeat (10) @(posedge wclk);
      #1;
      check("rst_writes_drained", 32'(expq.size()), 32'd0);
      check("no_done_after_rst", 32'(dones - d0), 32'd0);
    end else begin
      check("ready_low_after_last", 32'(in_ready), 32'd0);
      if (fb.size() > n) begin
        in_valid = 1'b1;
        in_data = fb[n];
        repeat (2) begin
          @(posedge wclk); #1;
          check("ready_low_extra", 32'(in_ready), 32'd0);
        end
      end
      in_valid = 1'b0;
      t = 0;
      while (expect_done && t < 50) begin
        @(posedge wclk); #1;
        t++;
      end
      check("done_seen", 32'(expect_done), 32'd0);
      @(posedge wclk); #1;
      check("busy_idle", 32'(busy), 32'd0);
      check("single_done", 32'(dones - d0), 32'd1);
    end
    expq.delete();
  endtask

  initial begin
    int len;
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h0;
    in_last = 1'b0;
    repeat (3) @(posedge wclk);
    #1;
    check("reset_outputs", {f1_wr_en, 25'h0, in_ready, ena, busy}, 32'd0);
    check("reset_waddr", f1_waddr, 32'd0);
    check("reset_wdata", f1_wdata, 32'd0);
    check("reset_done", 32'(done), 32'd0);
    rst = 1'b0;
    fb.delete();
    for (int i = 0; i < FB + 2; i++) fb.push_back(8'(i));
    run_frame(1'b0, 1'b0, 1'b0, 0);
    fb = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    run_frame(1'b1, 1'b0, 1'b0, 0);
    fb.delete();
    for (int i = 0; i < FB + 2; i++) fb.push_back(8'(i));
    run_frame(1'b0, 1'b1, 1'b0, 0);
    fb.delete();
    for (int i = 0; i < 16; i++) fb.push_back(8'($urandom));
    run_frame(1'b0, 1'b0, 1'b0, 7);
    fb.delete();
    for (int i = 0; i < 20; i++) fb.push_back(8'($urandom));
    run_frame(1'b1, 1'b1, 1'b1, 0);
    fb = '{8'h00, 8'h01, 8'h02, 8'h03};
    run_frame(1'b1, 1'b0, 1'b0, 0);
    fb.delete();
    for (int i = 0; i < 8; i++) fb.push_back(8'($urandom));
    run_frame(1'b1, 1'b1, 1'b0, 0);
    repeat (6) begin
      len = $urandom_range(1, 40);
      fb.delete();
      for (int i = 0; i < len; i++) fb.push_back(8'($urandom));
      run_frame(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/f1_ram_loader.md
F1_RAM_LOADER -- requirements
Module: f1_ram_loader

Interface
REQ-001 SHALL have parameter FRAME_BYTES, default 1024: number of feature bytes in one conv1 input frame (range 4..1024).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0: byte address of the first word written; a multiple of 4.
REQ-003 SHALL have port wclk  input  1: single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-005 SHALL have port start  input  1: one-cycle pulse that begins loading a frame.
REQ-006 SHALL have port in_valid  input  1: the byte on in_data is valid.
REQ-007 SHALL have port in_data  input  8: feature byte, in raster order.
REQ-008 SHALL have port in_last  input  1: qualified by in_valid; marks the final byte of a short frame.
REQ-009 SHALL have port in_ready  output  1: the loader accepts a byte this cycle.
REQ-010 SHALL have port f1_wr_en  output  4: per-byte write enables to the feature RAM.
REQ-011 SHALL have port f1_waddr  output  32: byte address of the word being written.
REQ-012 SHALL have port f1_wdata  output  32: packed word being written.
REQ-013 SHALL have port ena  output  1: feature RAM port-A enable.
REQ-014 SHALL have port busy  output  1: high from start acceptance until done.
REQ-015 SHALL have port done  output  1: one-cycle pulse when the frame is fully written.

Function
REQ-016 SHALL implement the states IDLE, LOAD, FLUSH and DONE.
REQ-017 SHALL move from IDLE to LOAD on start; start SHALL be ignored in every other state.
REQ-018 SHALL drive in_ready = 1 only in LOAD; a byte is accepted when in_valid and in_ready are both high.
REQ-019 SHALL pack bytes by lane: byte k of a word goes to wdata[8k+7:8k], where k = accepted_count mod 4.
REQ-020 SHALL, on acceptance of lane 3, drive a registered write in the next cycle: wr_en=4'b1111, ena=1, waddr=BASE_ADDR+4*word_index.
REQ-021 SHALL hold wr_en=0 and ena=0 in every cycle that has no write.
REQ-022 SHALL increment word_index after each write and never wrap it inside a frame.
REQ-023 SHALL, when the accepted byte count reaches FRAME_BYTES or an accepted byte has in_last=1, go to FLUSH with in_ready=0 from the next cycle on.
REQ-024 SHALL, in FLUSH, write any partial word with wr_en = ((1<<lanes_filled)-1) and unfilled lanes = 0; with no partial word there is no extra write.
REQ-025 SHALL move from FLUSH to DONE once the final write has been issued.
REQ-026 SHALL, in DONE, pulse done for one cycle, then return to IDLE and clear the counters.
REQ-027 SHALL keep busy = 1 in LOAD, FLUSH and DONE.
REQ-028 SHALL, when in_last arrives on lane 3, issue exactly one full-word write and no extra flush write.
REQ-029 SHALL NOT accept bytes beyond FRAME_BYTES; such bytes are left for the next frame.

Reset
REQ-030 SHALL, on rst, force IDLE and zero in_ready, f1_wr_en, f1_waddr, f1_wdata, ena, busy, done and all counters.
REQ-031 SHALL, on rst mid-frame, abandon the partial word with no write issued; rst SHALL take priority over start.

Configuration
REQ-032 SHALL, with F1_LOADER_BYTE_SWAP_EN defined, pack big-endian: byte k goes to lane 3-k and partial masks fill from lane 3 downward.
REQ-033 SHALL, without F1_LOADER_BYTE_SWAP_EN, use the little-endian packing of REQ-019 and REQ-024.

Structure
REQ-034 SHALL take the state enum, a default FRAME_BYTES constant and a lane-mask function from the shared package f1_pkg.
REQ-035 SHALL contain one sub-module, f1_byte_packer: lane counter, word register and mask generation; the FSM and address logic stay in the top.

Verification
REQ-036 SHALL cover a full frame: start, bytes 0x00..0xFF repeating, FRAME_BYTES=1024 -> 256 writes, addr 0x0..0x3FC, first wdata 0x03020100, done 1 cycle after last write.
REQ-037 SHALL cover a short frame: in_last on the 6th byte (0xA0..0xA5) -> writes 0xA3A2A1A0/4'hF at addr 0, then 0x0000A5A4/4'h3 at addr 4, then done.
REQ-038 SHALL cover back-pressure: in_valid toggled randomly -> identical write sequence to REQ-036, no lost or duplicated bytes.
REQ-039 SHALL cover reset mid-frame: rst after 7 accepted bytes -> one write only (addr 0), outputs zero next cycle, no done.
REQ-040 SHALL cover start while busy: second start during LOAD -> ignored, single done pulse.
REQ-041 SHALL cover byte swap with F1_LOADER_BYTE_SWAP_EN defined: bytes 0x00..0x03 -> wdata 0x00010203.
